// File: rtl/wb_mem_pkg.sv
// Shared types and width helpers for the Wishbone memory responder.
package wb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        RELEASE
    } state_t;

    function automatic int unsigned offset_width(input int unsigned word_size);
        return $clog2(word_size / 8);
    endfunction

    function automatic int unsigned index_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned count_width(input int unsigned rd_lat, input int unsigned wr_lat);
        return $clog2(((rd_lat > wr_lat) ? rd_lat : wr_lat) + 1);
    endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Single-port word array: synchronous write, combinational read at the same index.
module wb_mem_array
    import wb_mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 128,
    parameter int unsigned DEPTH     = 256
) (
    input  logic                           user_clk_i,
    input  logic                           wr_en,
    input  logic [index_width(DEPTH)-1:0]  idx,
    input  logic [WORD_SIZE-1:0]           wr_data,
    output logic [WORD_SIZE-1:0]           rd_data
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge user_clk_i) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

    assign rd_data = mem[idx];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone responder standing in for the DRAM user port: fixed-latency single-word access.
// Optional WB_MEM_ERR_EN adds err_o for addresses beyond the array instead of wrapping.
module wb_mem_responder
    import wb_mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = 128,
    parameter int unsigned DEPTH         = 256,
    parameter int unsigned READ_LATENCY  = 8,
    parameter int unsigned WRITE_LATENCY = 4
) (
    input  logic                 user_clk_i,
    input  logic                 rst_n_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [WORD_SIZE-1:0] data_i,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 ack_o,
    output logic                 busy_o
`ifdef WB_MEM_ERR_EN
    ,
    output logic                 err_o
`endif
);

    localparam int unsigned OFF_W = offset_width(WORD_SIZE);
    localparam int unsigned IDX_W = index_width(DEPTH);
    localparam int unsigned CNT_W = count_width(READ_LATENCY, WRITE_LATENCY);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 we_q;
    logic [IDX_W-1:0]     idx_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rd_data;
    logic [31:0]          word_addr;
    logic                 wr_en;

    assign word_addr = addr_i >> OFF_W;

`ifdef WB_MEM_ERR_EN
    logic oor_q;
`else
    logic unused_hi_bits;
    assign unused_hi_bits = |word_addr[31:IDX_W];
`endif

    // ack_o is suppressed for out-of-range requests, so it alone gates the commit
    assign wr_en = ack_o & we_q;

    wb_mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_array (
        .user_clk_i (user_clk_i),
        .wr_en      (wr_en),
        .idx        (idx_q),
        .wr_data    (wdata_q),
        .rd_data    (rd_data)
    );

    always_ff @(posedge user_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            cnt     <= '0;
            ack_o   <= 1'b0;
            busy_o  <= 1'b0;
            data_o  <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
`ifdef WB_MEM_ERR_EN
            err_o   <= 1'b0;
            oor_q   <= 1'b0;
`endif
        end else begin
            ack_o <= 1'b0;
`ifdef WB_MEM_ERR_EN
            err_o <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (cyc_i && stb_i) begin
                        we_q    <= we_i;
                        idx_q   <= word_addr[IDX_W-1:0];
                        wdata_q <= data_i;
`ifdef WB_MEM_ERR_EN
                        oor_q   <= |word_addr[31:IDX_W];
`endif
                        // loaded one short so the ack lands exactly LAT edges after acceptance
                        cnt     <= we_i ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
                        busy_o  <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!cyc_i) begin
                        cnt    <= '0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == '0) begin
                        state <= ACK;
`ifdef WB_MEM_ERR_EN
                        if (oor_q) begin
                            err_o <= 1'b1;
                        end else begin
                            ack_o <= 1'b1;
                            if (!we_q) begin
                                data_o <= rd_data;
                            end
                        end
`else
                        ack_o <= 1'b1;
                        if (!we_q) begin
                            data_o <= rd_data;
                        end
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!cyc_i || !stb_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed plus randomized check of wb_mem_responder against a word-array reference model.
module tb_wb_mem_responder;

    localparam int unsigned WS = 128;
    localparam int unsigned DP = 256;
    localparam int unsigned RL = 8;
    localparam int unsigned WL = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc   = 1'b0;
    logic          stb   = 1'b0;
    logic          we    = 1'b0;
    logic [31:0]   addr  = '0;
    logic [WS-1:0] wdat  = '0;
    logic [WS-1:0] rdat;
    logic          ack;
    logic          busy;
`ifdef WB_MEM_ERR_EN
    logic          err;
`endif

    int total = 0;
    int bad   = 0;

    logic [WS-1:0] model [DP];
    logic [WS-1:0] last_rd;

    always #5 clk = ~clk;

    wb_mem_responder #(
        .WORD_SIZE     (WS),
        .DEPTH         (DP),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .user_clk_i (clk),
        .rst_n_i    (rst_n),
        .cyc_i      (cyc),
        .stb_i      (stb),
        .we_i       (we),
        .addr_i     (addr),
        .data_i     (wdat),
        .data_o     (rdat),
        .ack_o      (ack),
        .busy_o     (busy)
`ifdef WB_MEM_ERR_EN
        ,
        .err_o      (err)
`endif
    );

    task automatic chk(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds the strobe for n_cyc cycles after acceptance, scrambling the request inputs meanwhile.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [WS-1:0] d, input int n_cyc,
                           output int acks, output int ack_at, output int errs, output int err_at,
                           output int busy_low, output logic [WS-1:0] rd);
        acks = 0; ack_at = -1; errs = 0; err_at = -1; busy_low = 0; rd = '0;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
        @(posedge clk); #1;
        if (!busy) busy_low++;
        we = ~w; addr = $urandom; wdat = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= n_cyc; k++) begin
            @(posedge clk); #1;
            if (ack) begin
                acks++;
                if (ack_at < 0) begin ack_at = k; rd = rdat; end
            end
`ifdef WB_MEM_ERR_EN
            if (err) begin
                errs++;
                if (err_at < 0) err_at = k;
            end
`endif
            if (!busy) busy_low++;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic txn_check(input string tag, input logic w, input logic [31:0] a, input logic [WS-1:0] d);
        int acks, at, errs, eat, bl;
        logic [WS-1:0] rd;
        int idx;
        idx = int'((a / (WS / 8)) % DP);
        run_txn(w, a, d, 12, acks, at, errs, eat, bl, rd);
        chk({tag, "_acks"}, WS'(acks), WS'(1));
        chk({tag, "_lat"}, WS'(at), w ? WS'(WL) : WS'(RL));
        chk({tag, "_errs"}, WS'(errs), WS'(0));
        chk({tag, "_busy_held"}, WS'(bl), WS'(0));
        chk({tag, "_busy_fall"}, WS'(busy), WS'(0));
        if (w) begin
            chk({tag, "_dout_kept"}, rd, last_rd);
            model[idx] = d;
        end else begin
            chk({tag, "_rdata"}, rd, model[idx]);
            last_rd = model[idx];
        end
    endtask

    initial begin
        int acks, at, errs, eat, bl;
        logic [WS-1:0] rd;
        logic [31:0] a;
        logic [WS-1:0] d;
        logic w;

        last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", WS'(ack), WS'(0));
        chk("rst_busy", WS'(busy), WS'(0));
        chk("rst_dout", rdat, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // round trip
        txn_check("wr10", 1'b1, 32'h10, 128'hAABBCCDDEEFF00112233445566778899);
        txn_check("rd10", 1'b0, 32'h10, '0);

        // held strobe: one ack, busy stays up, falls one edge after release
        run_txn(1'b0, 32'h10, '0, RL + 20, acks, at, errs, eat, bl, rd);
        chk("hold_acks", WS'(acks), WS'(1));
        chk("hold_lat", WS'(at), WS'(RL));
        chk("hold_busy_low", WS'(bl), WS'(0));
        chk("hold_busy_fall", WS'(busy), WS'(0));
        chk("hold_rdata", rd, model[1]);

        // abort
        txn_check("wr20", 1'b1, 32'h20, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h20; wdat = 128'h1234;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        chk("abort_acks", WS'(acks), WS'(0));
        chk("abort_busy", WS'(busy), WS'(0));
        txn_check("rd20_after_abort", 1'b0, 32'h20, '0);

`ifndef WB_MEM_ERR_EN
        // wrap and byte offset
        txn_check("wr1010", 1'b1, 32'h1010, 128'h55);
        txn_check("rd10_wrap", 1'b0, 32'h10, '0);
        txn_check("rd1f_off", 1'b0, 32'h1F, '0);
`else
        txn_check("wr10_55", 1'b1, 32'h10, 128'h55);
        txn_check("rd10_55", 1'b0, 32'h10, '0);
`endif

        // reset in WAIT
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h20;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", WS'(ack), WS'(0));
        chk("midrst_busy", WS'(busy), WS'(0));
        chk("midrst_dout", rdat, '0);
        last_rd = '0;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        acks = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        chk("midrst_no_ack", WS'(acks), WS'(0));

`ifdef WB_MEM_ERR_EN
        txn_check("rd10_pre_err", 1'b0, 32'h10, '0);
        run_txn(1'b0, 32'h1010, '0, 12, acks, at, errs, eat, bl, rd);
        chk("err_acks", WS'(acks), WS'(0));
        chk("err_count", WS'(errs), WS'(1));
        chk("err_lat", WS'(eat), WS'(RL));
        chk("err_dout_kept", rdat, last_rd);
        run_txn(1'b1, 32'h1010, 128'h99, 12, acks, at, errs, eat, bl, rd);
        chk("err_wr_count", WS'(errs), WS'(1));
        txn_check("rd10_after_err_wr", 1'b0, 32'h10, '0);
`endif

        // randomized traffic over eight words
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            txn_check("preload", 1'b1, 32'(i * 16), d);
        end
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
`ifndef WB_MEM_ERR_EN
            a = a + 32'($urandom_range(0, 3) * 32'h1000);
`endif
            d = {$urandom, $urandom, $urandom, $urandom};
            txn_check(w ? "rand_wr" : "rand_rd", w, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_mem_responder.md
# wb_mem_responder

Synthesizable Wishbone responder that stands in for the DRAM controller's user-side port: it accepts single-word read/write transactions from an initiator, holds them for a configurable latency, and acknowledges with data from a small internal word array. It sits at the responder end of the user-clock Wishbone link and lets initiators and benches run without the DDR3 PHY or the memory interface generator.

## Interface
- WORD_SIZE, 128: data word width in bits; multiple of 8, power of two.
- DEPTH, 256: number of words in the internal array; power of two, ≥ 2.
- READ_LATENCY, 8: cycles from request acceptance to ack for reads; ≥ 1.
- WRITE_LATENCY, 4: cycles from request acceptance to ack for writes; ≥ 1.

- user_clk_i  in  1  single clock; all logic on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  transfer strobe.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address.
- data_i  in  WORD_SIZE  write data.
- data_o  out  WORD_SIZE  read data; valid while ack_o = 1.
- ack_o  out  1  single-cycle transaction acknowledge.
- busy_o  out  1  high from acceptance through the release wait.

## Operation
- Word index = addr_i >> log2(WORD_SIZE/8). Low byte-offset bits are ignored. The index is taken modulo DEPTH, so addresses wrap (unless WB_MEM_ERR_EN is defined).
- FSM states:
  - IDLE: when cyc_i & stb_i are high, latch we_i, the word index and data_i, load the counter with the latency for the operation, and go to WAIT.
  - WAIT: decrement the counter each cycle. At zero, go to ACK.
  - ACK: ack_o = 1 for exactly one cycle. A write is committed to the array in this cycle. For a read, data_o = array[index]. Then go to RELEASE.
  - RELEASE: stay until cyc_i = 0 or stb_i = 0, then go to IDLE. A strobe held high after ack never starts a second transaction; each transaction needs a fresh strobe assertion.
- Abort: if cyc_i goes low in WAIT, go to IDLE with no ack and no array write.
- data_o holds the last read value outside ack; it is never updated by writes.
- Inputs are sampled only in IDLE. Changes in data_i, addr_i or we_i after acceptance are ignored.
- Reset clears the FSM to IDLE, the counter, ack_o, busy_o and data_o to 0. Array contents are not reset, and a reset during a transaction discards it (no write, no ack).

## Timing
- Request accepted at rising edge N (IDLE, cyc_i & stb_i = 1) → ack_o high during the cycle after edge N+LAT, where LAT is the read or write latency.
- busy_o rises after edge N and falls on the edge that moves RELEASE to IDLE.
- Back-to-back: if strobe drops at edge M and rises again, the earliest new acceptance is edge M+1 (the IDLE cycle).
- Counter width = $clog2(max(READ_LATENCY, WRITE_LATENCY)+1).

## Configuration
- WB_MEM_ERR_EN:
  - Defined: adds output err_o (1 bit, reset 0). An index ≥ DEPTH before wrap (any address bit above the index field set) is still accepted and still waits out its latency, but in the ACK-equivalent cycle err_o = 1 and ack_o = 0. No array write is made and data_o is unchanged.
  - Undefined: no err_o port; out-of-range addresses wrap modulo DEPTH.

## Structure
- Package wb_mem_pkg holds:
  - state enum (IDLE, WAIT, ACK, RELEASE);
  - localparam-style functions for the byte-offset width and index width.
- Sub-module wb_mem_array: single-port array with synchronous write enable and combinational read at the latched index, parameterized by WORD_SIZE and DEPTH.
- The top level contains the FSM, latency counter, request latches and output registers.

## Test plan
- **Write/read round trip:** write 0x10 ← 0xAABBCCDDEEFF00112233445566778899, then read 0x10 → ack with data_o = the same value.
- **Latency and ack width:** read accepted at edge N, defaults → ack_o high only in the cycle after edge N+8. A write shows ack after edge N+4. Each ack is exactly one cycle wide.
- **Held strobe:** keep stb_i and cyc_i high for 20 cycles after ack → exactly one ack, busy_o stays 1. After deasserting, busy_o falls the next edge.
- **Abort:** start a write of 0x1234 at 0x20, drop cyc_i 2 cycles after acceptance → no ack. A later read of 0x20 returns the prior contents.
- **Wrap and offset:** write 0x55 at 0x1010 (DEPTH = 256, 16-byte words) → read of 0x10 returns 0x55. A read of 0x1F returns the same word.
- **Reset mid-read and error option:** assert rst_n_i in WAIT → ack_o, busy_o and data_o = 0 immediately, no ack afterwards. With WB_MEM_ERR_EN, a read of 0x1010 → err_o pulse, no ack.
